buffer_read_ctrl: RTL and testbench

Readout sequencer for the raw-hits FIFO RAM fence buffer. When the fence queue holds an event and the readout path is ready, it reads that event's time bins from the RAM and streams them with framing flags. It then releases the fence by popping the queue with the matching address. It sits between the fence queue status outputs and the DMB readout/header machine, and is the sole issuer of buf_pop.

---
 rtl/buffer_read_ctrl_pkg.sv | 25 ++
 rtl/buffer_read_ctrl_rd_valid_pipe.sv | 41 ++++
 rtl/buffer_read_ctrl.sv | 136 +++++++++++++
 tb/tb_buffer_read_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_read_ctrl_pkg.sv
// Shared definitions for the raw-hits fence buffer readout sequencer.
package buffer_read_ctrl_pkg;

    // Default widths and timing.
    localparam int MXTBIN_DEF     = 5;
    localparam int RAM_ADRB_DEF   = 11;
    localparam int MXBADR_DEF     = 11;
    localparam int MXBDATA_DEF    = 32;
    localparam int RD_LATENCY_DEF = 2;
    localparam int POP_SETTLE_DEF = 2;

    // Width of the shared drain/settle wait counter (covers up to 16 clocks).
    localparam int WAIT_CNT_W     = 4;

    // Readout sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_READ,
        ST_DRAIN,
        ST_POP,
        ST_SETTLE
    } rd_state_t;

endpackage

// File: rtl/buffer_read_ctrl_rd_valid_pipe.sv
// Fixed-latency shift register that carries {ren, first, last, tbin} so the
// framing flags line up with the data coming out of the raw-hits RAM.
module rd_valid_pipe #(
    parameter int LATENCY = 2,
    parameter int TBIN_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ren,
    input  logic              first,
    input  logic              last,
    input  logic [TBIN_W-1:0] tbin,
    output logic              valid,
    output logic              valid_first,
    output logic              valid_last,
    output logic [TBIN_W-1:0] valid_tbin
);

    localparam int W = TBIN_W + 3;

    logic [W-1:0] stage [LATENCY];
    logic [W-1:0] entry;

    // Flags and tbin are zeroed on idle clocks so the outputs stay quiet.
    assign entry = ren ? {1'b1, first, last, tbin} : '0;

    // Shift the read tag down the pipe; reset flushes words still in flight.
    // NOTE: these few stages are flops, not RAM, so resetting them is cheap and
    // guarantees no stale rd_valid after an aborted event.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
        end else begin
            stage[0] <= entry;
            for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
        end
    end

    assign {valid, valid_first, valid_last, valid_tbin} = stage[LATENCY-1];

endmodule

// File: rtl/buffer_read_ctrl.sv
// Readout sequencer: reads one fenced event's time bins from the raw-hits RAM,
// frames them for the readout machine, then releases the fence with buf_pop.
module buffer_read_ctrl
    import buffer_read_ctrl_pkg::*;
#(
    parameter int MXTBIN     = MXTBIN_DEF,
    parameter int RAM_ADRB   = RAM_ADRB_DEF,
    parameter int MXBADR     = MXBADR_DEF,
    parameter int MXBDATA    = MXBDATA_DEF,
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int POP_SETTLE = POP_SETTLE_DEF
) (
    input  logic                clock,
    input  logic                ttc_resync,
    input  logic                buf_q_empty,
    input  logic [MXBADR-1:0]   buf_queue_adr,
    input  logic [MXBDATA-1:0]  buf_queue_data,
    input  logic [MXTBIN-1:0]   fifo_tbins,
    input  logic [MXTBIN-1:0]   fifo_pretrig,
    input  logic                rd_ready,
    output logic                fifo_ren,
    output logic [RAM_ADRB-1:0] fifo_radr,
    output logic                rd_valid,
    output logic                rd_first,
    output logic                rd_last,
    output logic [MXTBIN-1:0]   rd_tbin,
    output logic [MXBDATA-1:0]  rd_event_data,
    output logic                rd_busy,
    output logic                buf_pop,
    output logic [MXBADR-1:0]   buf_pop_adr,
    output logic [15:0]         rd_event_cnt
);

    rd_state_t                 state, state_nxt;
    logic [MXBADR-1:0]         adr_r;
    logic [RAM_ADRB-1:0]       radr_r;
    logic [MXTBIN-1:0]         tbins_r;
    logic [MXTBIN-1:0]         tbin_r;
    logic [WAIT_CNT_W-1:0]     wait_cnt;
    logic [15:0]               event_cnt;
    logic [MXBDATA-1:0]        event_data_r;
    logic                      issue;
    logic                      last_tbin;
    logic                      pipe_valid;

    assign last_tbin = (tbin_r == tbins_r - MXTBIN'(1));

    // State register.
    // NOTE: every clocked block uses non-blocking assignments so all flops
    // update together from values sampled before the edge.
    always_ff @(posedge clock) begin
        if (ttc_resync) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // Next-state and read-issue decode.
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            ST_IDLE:   if (!buf_q_empty && rd_ready) state_nxt = ST_LATCH;
            ST_LATCH:  state_nxt = (fifo_tbins != '0) ? ST_READ : ST_POP;
            ST_READ: begin
                if (rd_ready) begin
                    issue = 1'b1;
                    if (last_tbin) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN:  if (wait_cnt == WAIT_CNT_W'(RD_LATENCY - 1)) state_nxt = ST_POP;
            ST_POP:    state_nxt = ST_SETTLE;
            ST_SETTLE: if (wait_cnt == WAIT_CNT_W'(POP_SETTLE - 1)) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Event context, read address/tbin counters, wait timer and event counter.
    always_ff @(posedge clock) begin
        if (ttc_resync) begin
            adr_r        <= '0;
            radr_r       <= '0;
            tbins_r      <= '0;
            tbin_r       <= '0;
            wait_cnt     <= '0;
            event_cnt    <= '0;
            event_data_r <= '0;
        end else begin
            if (state == ST_LATCH) begin
                adr_r        <= buf_queue_adr;
                event_data_r <= buf_queue_data;
                tbins_r      <= fifo_tbins;
                radr_r       <= RAM_ADRB'(buf_queue_adr) - RAM_ADRB'(fifo_pretrig);
                tbin_r       <= '0;
            end
            if (issue) begin
                radr_r <= radr_r + RAM_ADRB'(1);
                tbin_r <= tbin_r + MXTBIN'(1);
            end
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (state == ST_DRAIN || state == ST_SETTLE)
                wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
            if (state == ST_POP && event_cnt != 16'hFFFF)
                event_cnt <= event_cnt + 16'd1;
        end
    end

    // Pulses are suppressed while resync is asserted so an aborted event
    // issues nothing in the reset clock.
    assign fifo_ren      = issue & ~ttc_resync;
    assign fifo_radr     = radr_r;
    assign buf_pop       = (state == ST_POP) & ~ttc_resync;
    assign buf_pop_adr   = adr_r;
    assign rd_busy       = (state != ST_IDLE);
    assign rd_event_cnt  = event_cnt;
    assign rd_event_data = event_data_r;

    rd_valid_pipe #(
        .LATENCY (RD_LATENCY),
        .TBIN_W  (MXTBIN)
    ) u_rd_valid_pipe (
        .clock       (clock),
        .reset       (ttc_resync),
        .ren         (fifo_ren),
        .first       (tbin_r == '0),
        .last        (last_tbin),
        .tbin        (tbin_r),
        .valid       (pipe_valid),
        .valid_first (rd_first),
        .valid_last  (rd_last),
        .valid_tbin  (rd_tbin)
    );

    assign rd_valid = pipe_valid & ~ttc_resync;

endmodule

// File: tb/tb_buffer_read_ctrl.sv
// Directed bench for buffer_read_ctrl: table of single events plus
// back-to-back and mid-event resync sequences.
module tb_buffer_read_ctrl;

    localparam int RD_LATENCY = 2;
    localparam int POP_SETTLE = 2;

    logic        clock = 1'b0;
    logic        ttc_resync;
    logic        buf_q_empty;
    logic [10:0] buf_queue_adr;
    logic [31:0] buf_queue_data;
    logic [4:0]  fifo_tbins;
    logic [4:0]  fifo_pretrig;
    logic        rd_ready;
    logic        fifo_ren;
    logic [10:0] fifo_radr;
    logic        rd_valid;
    logic        rd_first;
    logic        rd_last;
    logic [4:0]  rd_tbin;
    logic [31:0] rd_event_data;
    logic        rd_busy;
    logic        buf_pop;
    logic [10:0] buf_pop_adr;
    logic [15:0] rd_event_cnt;

    buffer_read_ctrl #(
        .MXTBIN(5), .RAM_ADRB(11), .MXBADR(11), .MXBDATA(32),
        .RD_LATENCY(RD_LATENCY), .POP_SETTLE(POP_SETTLE)
    ) dut (
        .clock          (clock),
        .ttc_resync     (ttc_resync),
        .buf_q_empty    (buf_q_empty),
        .buf_queue_adr  (buf_queue_adr),
        .buf_queue_data (buf_queue_data),
        .fifo_tbins     (fifo_tbins),
        .fifo_pretrig   (fifo_pretrig),
        .rd_ready       (rd_ready),
        .fifo_ren       (fifo_ren),
        .fifo_radr      (fifo_radr),
        .rd_valid       (rd_valid),
        .rd_first       (rd_first),
        .rd_last        (rd_last),
        .rd_tbin        (rd_tbin),
        .rd_event_data  (rd_event_data),
        .rd_busy        (rd_busy),
        .buf_pop        (buf_pop),
        .buf_pop_adr    (buf_pop_adr),
        .rd_event_cnt   (rd_event_cnt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor logs, sampled on the falling edge.
    typedef struct { int cyc; logic [10:0] adr; } adr_rec_t;
    typedef struct { int cyc; logic [4:0] tbin; logic first; logic last; } val_rec_t;
    adr_rec_t ren_log[$];
    adr_rec_t pop_log[$];
    val_rec_t val_log[$];
    int       lat_log[$];
    logic     prev_busy = 1'b0;

    always @(negedge clock) begin
        if (fifo_ren) ren_log.push_back('{cyc, fifo_radr});
        if (rd_valid) val_log.push_back('{cyc, rd_tbin, rd_first, rd_last});
        if (buf_pop)  pop_log.push_back('{cyc, buf_pop_adr});
        if (rd_busy && !prev_busy) lat_log.push_back(cyc);
        prev_busy = rd_busy;
    end

    // Fence queue model.
    typedef struct { logic [10:0] adr; logic [31:0] data; } ev_t;
    ev_t evq[$];
    int  pops_applied = 0;

    typedef struct {
        logic [10:0] adr;
        logic [31:0] data;
        logic [4:0]  pretrig;
        logic [4:0]  tbins;
        int          stall_at;
        int          stall_len;
        int          exp_nrd;
        logic [10:0] exp_radr0;
        logic [15:0] exp_cnt;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic refresh_head();
        buf_q_empty    = (evq.size() == 0);
        buf_queue_adr  = (evq.size() == 0) ? 11'd0 : evq[0].adr;
        buf_queue_data = (evq.size() == 0) ? 32'd0 : evq[0].data;
    endtask

    // Advance one clock; inputs are driven 1ns after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
        while (pops_applied < pop_log.size()) begin
            if (evq.size() != 0) void'(evq.pop_front());
            pops_applied++;
        end
        refresh_head();
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_fifo_ren"},  64'(fifo_ren), 64'd0);
        check({pfx, "_fifo_radr"}, 64'(fifo_radr), 64'd0);
        check({pfx, "_rd_valid"},  64'({rd_valid, rd_first, rd_last, rd_tbin}), 64'd0);
        check({pfx, "_rd_busy"},   64'(rd_busy), 64'd0);
        check({pfx, "_buf_pop"},   64'({buf_pop, buf_pop_adr}), 64'd0);
        check({pfx, "_event_cnt"}, 64'(rd_event_cnt), 64'd0);
        check({pfx, "_event_data"}, 64'(rd_event_data), 64'd0);
    endtask

    task automatic run_event(input int idx, input vec_t v);
        int r0, v0, p0, l0, nrd, nval, bad, stalled, budget;
        logic finished;
        r0 = ren_log.size(); v0 = val_log.size(); p0 = pop_log.size(); l0 = lat_log.size();
        stalled = 0; finished = 1'b0;
        fifo_tbins   = v.tbins;
        fifo_pretrig = v.pretrig;
        rd_ready     = 1'b1;
        evq.push_back('{v.adr, v.data});
        refresh_head();
        for (budget = 0; budget < 200; budget++) begin
            if (v.stall_len > 0 && (ren_log.size() - r0) == v.stall_at && stalled < v.stall_len) begin
                rd_ready = 1'b0;
                stalled++;
            end else begin
                rd_ready = 1'b1;
            end
            step();
            if (pop_log.size() > p0 && !rd_busy) begin
                finished = 1'b1;
                break;
            end
        end
        check($sformatf("v%0d_done", idx), 64'(finished), 64'd1);
        nrd = ren_log.size() - r0;
        check($sformatf("v%0d_nreads", idx), 64'(nrd), 64'(v.exp_nrd));
        if (nrd > 0)
            check($sformatf("v%0d_radr0", idx), 64'(ren_log[r0].adr), 64'(v.exp_radr0));
        bad = 0;
        for (int k = 0; k < nrd; k++)
            if (ren_log[r0+k].adr !== v.exp_radr0 + 11'(k)) bad++;
        check($sformatf("v%0d_radr_seq_errs", idx), 64'(bad), 64'd0);
        nval = val_log.size() - v0;
        check($sformatf("v%0d_nvalid", idx), 64'(nval), 64'(v.exp_nrd));
        bad = 0;
        for (int k = 0; k < nval && k < nrd; k++) begin
            if (val_log[v0+k].cyc != ren_log[r0+k].cyc + RD_LATENCY) bad++;
            if (val_log[v0+k].tbin != 5'(k)) bad++;
            if (val_log[v0+k].first != (k == 0)) bad++;
            if (val_log[v0+k].last != (k == v.exp_nrd - 1)) bad++;
        end
        check($sformatf("v%0d_valid_align_errs", idx), 64'(bad), 64'd0);
        check($sformatf("v%0d_npop", idx), 64'(pop_log.size() - p0), 64'd1);
        if (pop_log.size() > p0) begin
            check($sformatf("v%0d_pop_adr", idx), 64'(pop_log[p0].adr), 64'(v.adr));
            if (nrd > 0)
                check($sformatf("v%0d_pop_after_last_ren", idx),
                      64'(pop_log[p0].cyc - ren_log[r0+nrd-1].cyc), 64'd3);
            else if (lat_log.size() > l0)
                check($sformatf("v%0d_pop_after_latch", idx),
                      64'(pop_log[p0].cyc - lat_log[l0]), 64'd1);
        end
        if (v.stall_len > 0 && nrd > v.stall_at)
            check($sformatf("v%0d_stall_gap", idx),
                  64'(ren_log[r0+v.stall_at].cyc - ren_log[r0+v.stall_at-1].cyc),
                  64'(v.stall_len + 1));
        check($sformatf("v%0d_event_cnt", idx), 64'(rd_event_cnt), 64'(v.exp_cnt));
        check($sformatf("v%0d_event_data", idx), 64'(rd_event_data), 64'(v.data));
        check($sformatf("v%0d_pop_adr_hold", idx), 64'(buf_pop_adr), 64'(v.adr));
    endtask

    initial begin
        vec_t vecs[6];
        int   r0, v0, p0, l0, budget;
        logic finished;

        //         adr      data           pre  tbin stall@ len nrd radr0  cnt
        vecs[0] = '{11'd100,  32'hA0A0_0001, 5'd7,  5'd4,  0, 0, 4,  11'd93,   16'd1};
        vecs[1] = '{11'd3,    32'hA0A0_0002, 5'd5,  5'd6,  0, 0, 6,  11'd2046, 16'd2};
        vecs[2] = '{11'd500,  32'hA0A0_0003, 5'd0,  5'd0,  0, 0, 0,  11'd0,    16'd3};
        vecs[3] = '{11'd1000, 32'hA0A0_0004, 5'd2,  5'd8,  2, 5, 8,  11'd998,  16'd4};
        vecs[4] = '{11'd2047, 32'hA0A0_0005, 5'd31, 5'd1,  0, 0, 1,  11'd2016, 16'd5};
        vecs[5] = '{11'd10,   32'hA0A0_0006, 5'd0,  5'd31, 0, 0, 31, 11'd10,   16'd6};

        ttc_resync   = 1'b1;
        rd_ready     = 1'b0;
        fifo_tbins   = '0;
        fifo_pretrig = '0;
        refresh_head();
        repeat (3) step();
        check_all_zero("reset");
        ttc_resync = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_event(i, vecs[i]);

        // Two events queued together.
        r0 = ren_log.size(); p0 = pop_log.size(); l0 = lat_log.size(); finished = 1'b0;
        fifo_tbins = 5'd2; fifo_pretrig = 5'd1; rd_ready = 1'b1;
        evq.push_back('{11'd200, 32'hB0B0_0001});
        evq.push_back('{11'd300, 32'hB0B0_0002});
        refresh_head();
        for (budget = 0; budget < 300; budget++) begin
            step();
            if (pop_log.size() >= p0 + 2 && !rd_busy) begin
                finished = 1'b1;
                break;
            end
        end
        check("b2b_done", 64'(finished), 64'd1);
        check("b2b_npop", 64'(pop_log.size() - p0), 64'd2);
        check("b2b_nreads", 64'(ren_log.size() - r0), 64'd4);
        if (pop_log.size() >= p0 + 2) begin
            check("b2b_pop_adr0", 64'(pop_log[p0].adr), 64'd200);
            check("b2b_pop_adr1", 64'(pop_log[p0+1].adr), 64'd300);
        end
        if (ren_log.size() >= r0 + 4) begin
            check("b2b_radr2", 64'(ren_log[r0+2].adr), 64'd299);
            check("b2b_radr3", 64'(ren_log[r0+3].adr), 64'd300);
        end
        if (lat_log.size() >= l0 + 2 && pop_log.size() > p0)
            check("b2b_relaunch_gap_ok",
                  64'((lat_log[l0+1] - pop_log[p0].cyc) >= POP_SETTLE + 1), 64'd1);
        check("b2b_event_cnt", 64'(rd_event_cnt), 64'd8);

        // Resync while tbin 3 is being read.
        r0 = ren_log.size(); v0 = val_log.size(); p0 = pop_log.size(); finished = 1'b0;
        fifo_tbins = 5'd8; fifo_pretrig = 5'd4; rd_ready = 1'b1;
        evq.push_back('{11'd600, 32'hC0C0_0001});
        refresh_head();
        for (budget = 0; budget < 50; budget++) begin
            step();
            if (ren_log.size() - r0 == 3) begin
                finished = 1'b1;
                break;
            end
        end
        check("rst_reached_tbin3", 64'(finished), 64'd1);
        ttc_resync = 1'b1;
        step();
        check_all_zero("midrst");
        check("midrst_no_pop", 64'(pop_log.size() - p0), 64'd0);
        check("midrst_nreads", 64'(ren_log.size() - r0), 64'd3);
        check("midrst_nvalid", 64'(val_log.size() - v0), 64'd1);
        ttc_resync = 1'b0;

        // The un-popped event relaunches from tbin 0.
        r0 = ren_log.size(); v0 = val_log.size(); finished = 1'b0;
        for (budget = 0; budget < 200; budget++) begin
            step();
            if (pop_log.size() > p0 && !rd_busy) begin
                finished = 1'b1;
                break;
            end
        end
        check("relaunch_done", 64'(finished), 64'd1);
        check("relaunch_nreads", 64'(ren_log.size() - r0), 64'd8);
        if (ren_log.size() > r0)
            check("relaunch_radr0", 64'(ren_log[r0].adr), 64'd596);
        if (val_log.size() > v0)
            check("relaunch_first", 64'({val_log[v0].first, val_log[v0].tbin}), 64'({1'b1, 5'd0}));
        if (pop_log.size() > p0)
            check("relaunch_pop_adr", 64'(pop_log[p0].adr), 64'd600);
        check("relaunch_event_cnt", 64'(rd_event_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
